// File: rtl/zrb_uart_pkg.sv
// -----------------------------------------------------------------------------
// zrb_uart_pkg : shared FSM encoding and sample-point helpers for the UART RX (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

package zrb_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Three sample points straddle the nominal bit centre.
  function automatic int sample_first(input int oversample);
    return oversample / 2 - 1;
  endfunction

  function automatic int sample_mid(input int oversample);
    return oversample / 2;
  endfunction

  function automatic int sample_last(input int oversample);
    return oversample / 2 + 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

`default_nettype wire

// File: rtl/zrb_uart_receiver_if.sv
// -----------------------------------------------------------------------------
// zrb_uart_receiver_if : write port from the UART RX into a downstream FIFO (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

interface zrb_uart_receiver_if #(
  parameter int DATA_BITS = 8
) ();

  logic                 wr_en;
  logic [DATA_BITS-1:0] wr_data;
  logic                 fifo_full;

  modport master (output wr_en, output wr_data, input  fifo_full);
  modport slave  (input  wr_en, input  wr_data, output fifo_full);

endinterface

`default_nettype wire

// File: rtl/zrb_sync2.sv
// -----------------------------------------------------------------------------
// zrb_sync2 : two-flop synchronizer with configurable reset value (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module zrb_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ff_q <= {2{RESET_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

`default_nettype wire

// File: rtl/zrb_uart_receiver.sv
// -----------------------------------------------------------------------------
// zrb_uart_receiver : oversampled UART receiver with majority-vote bit sampling (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module zrb_uart_receiver
  import zrb_uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8
) (
  input  logic                       wr_clk,
  input  logic                       reset,
  input  logic                       tick,
  input  logic                       rx,
  zrb_uart_receiver_if.master        wr_port,
  output logic                       frame_err,
  output logic                       overrun,
  output logic                       busy
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS + 1);

  localparam logic [CNT_W-1:0] C_S_FIRST = CNT_W'(sample_first(OVERSAMPLE));
  localparam logic [CNT_W-1:0] C_S_MID   = CNT_W'(sample_mid(OVERSAMPLE));
  localparam logic [CNT_W-1:0] C_S_LAST  = CNT_W'(sample_last(OVERSAMPLE));
  localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] C_BIT_MAX = BIT_W'(DATA_BITS - 1);

  rx_state_e            state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [CNT_W-1:0]     cnt_d;
  logic [BIT_W-1:0]     bit_q;
  logic [1:0]           samp_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] shift_d;
  logic [DATA_BITS-1:0] wr_data_q;
  logic                 wr_en_q;
  logic                 frame_err_q;
  logic                 overrun_q;
  logic                 rx_s;
  logic                 vote;

  zrb_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
    .clk   (wr_clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // The third sample is taken live so the voted bit is acted on in the same tick.
  assign vote    = maj3(samp_q[0], samp_q[1], rx_s);
  assign cnt_d   = (cnt_q == C_CNT_MAX) ? '0 : cnt_q + 1'b1;
  assign shift_d = {vote, shift_q[DATA_BITS-1:1]};

  always_ff @(posedge wr_clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      samp_q      <= 2'b11;
      shift_q     <= '0;
      wr_data_q   <= '0;
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      wr_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      if (tick) begin
        case (state_q)
          ST_IDLE: begin
            if (!rx_s) begin
              state_q <= ST_START;
              cnt_q   <= '0;
              bit_q   <= '0;
            end
          end
          ST_START, ST_DATA, ST_STOP: begin
            cnt_q <= cnt_d;
            if (cnt_q == C_S_FIRST) samp_q[0] <= rx_s;
            if (cnt_q == C_S_MID)   samp_q[1] <= rx_s;
            if (cnt_q == C_S_LAST) begin
              if (state_q == ST_START) begin
                state_q <= vote ? ST_IDLE : ST_DATA;
              end else if (state_q == ST_DATA) begin
                shift_q <= shift_d;
                if (bit_q == C_BIT_MAX) begin
                  bit_q   <= '0;
                  state_q <= ST_STOP;
                end else begin
                  bit_q <= bit_q + 1'b1;
                end
              end else if (!vote) begin
                frame_err_q <= 1'b1;
                state_q     <= ST_BREAK;
              end else begin
                // Leaving at the stop-bit centre lets a back-to-back start edge be caught.
                if (wr_port.fifo_full) begin
                  overrun_q <= 1'b1;
                end else begin
                  wr_en_q   <= 1'b1;
                  wr_data_q <= shift_q;
                end
                state_q <= ST_IDLE;
              end
            end
          end
          ST_BREAK: begin
            if (rx_s) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign wr_port.wr_en   = wr_en_q;
  assign wr_port.wr_data = wr_data_q;
  assign frame_err       = frame_err_q;
  assign overrun         = overrun_q;
  assign busy            = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_zrb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_zrb_uart_receiver : randomized self-checking bench with a frame-level reference model (rev 1.0)
// -----------------------------------------------------------------------------
`default_nettype none

module tb_zrb_uart_receiver;

  localparam int DB   = 8;
  localparam int OS   = 8;
  localparam int TDIV = 4;

  localparam logic [1:0] EV_WR = 2'd1;
  localparam logic [1:0] EV_FE = 2'd2;
  localparam logic [1:0] EV_OV = 2'd3;

  logic wr_clk = 1'b0;
  logic reset  = 1'b1;
  logic tick   = 1'b0;
  logic rx     = 1'b1;
  logic frame_err;
  logic overrun;
  logic busy;

  zrb_uart_receiver_if #(.DATA_BITS(DB)) wr_if ();

  zrb_uart_receiver #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .wr_clk    (wr_clk),
    .reset     (reset),
    .tick      (tick),
    .rx        (rx),
    .wr_port   (wr_if),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 wr_clk = ~wr_clk;

  int          tick_div   = 0;
  int unsigned tick_count = 0;

  always @(negedge wr_clk) begin
    if (tick_div == TDIV - 1) begin
      tick_div = 0;
      tick     = 1'b1;
      tick_count++;
    end else begin
      tick_div++;
      tick = 1'b0;
    end
  end

  logic [DB+1:0] act_q[$];
  logic [DB+1:0] exp_q[$];
  int            excl_viol = 0;
  logic [DB-1:0] model_data = '0;

  // Monitor: log every output event; simultaneous events are counted as violations.
  always @(negedge wr_clk) begin
    if (!reset) begin
      if (wr_if.wr_en) act_q.push_back({EV_WR, wr_if.wr_data});
      if (frame_err)   act_q.push_back({EV_FE, {DB{1'b0}}});
      if (overrun)     act_q.push_back({EV_OV, {DB{1'b0}}});
      if ((int'(wr_if.wr_en) + int'(frame_err) + int'(overrun)) > 1) excl_viol++;
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_ticks(input int n);
    int unsigned tgt;
    tgt = tick_count + n;
    while (tick_count < tgt) @(negedge wr_clk);
  endtask

  // Reference model: outcome of a whole frame from the line-level protocol rules.
  task automatic model_frame(input logic [DB-1:0] data, input logic stop_ok, input logic full);
    if (!stop_ok) begin
      exp_q.push_back({EV_FE, {DB{1'b0}}});
    end else if (full) begin
      exp_q.push_back({EV_OV, {DB{1'b0}}});
    end else begin
      exp_q.push_back({EV_WR, data});
      model_data = data;
    end
  endtask

  task automatic send_frame(input logic [DB-1:0] data, input logic stop_bit);
    rx = 1'b0;
    wait_ticks(OS);
    for (int i = 0; i < DB; i++) begin
      rx = data[i];
      wait_ticks(OS);
    end
    rx = stop_bit;
    wait_ticks(OS);
  endtask

  task automatic compare_events(input string tag);
    logic [DB+1:0] a;
    logic [DB+1:0] e;
    chk({tag, "_count"}, act_q.size(), exp_q.size());
    while (act_q.size() > 0 && exp_q.size() > 0) begin
      a = act_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_event"}, 32'(a), 32'(e));
    end
    act_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [DB-1:0] d;
    logic          stop_ok;
    logic          full;
    int            gap;

    wr_if.fifo_full = 1'b0;
    repeat (3) @(negedge wr_clk);
    chk("rst_wr_en", wr_if.wr_en, 0);
    chk("rst_wr_data", wr_if.wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    reset = 1'b0;
    wait_ticks(2 * OS);

    // Single clean frame
    model_frame(8'h55, 1'b1, 1'b0);
    send_frame(8'h55, 1'b1);
    rx = 1'b1;
    wait_ticks(OS);
    compare_events("f55");
    chk("f55_busy", busy, 0);
    chk("f55_data", wr_if.wr_data, 8'h55);

    // Back-to-back frames with no idle gap
    model_frame(8'hA3, 1'b1, 1'b0);
    model_frame(8'h0F, 1'b1, 1'b0);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    rx = 1'b1;
    wait_ticks(OS);
    compare_events("b2b");

    // Two-tick low glitch is a false start
    rx = 1'b0;
    wait_ticks(2);
    rx = 1'b1;
    wait_ticks(2 * OS);
    compare_events("glitch");
    chk("glitch_busy", busy, 0);

    // Bad stop bit followed by a held-low line
    model_frame(8'h3C, 1'b0, 1'b0);
    send_frame(8'h3C, 1'b0);
    wait_ticks(30);
    chk("break_busy", busy, 1);
    compare_events("break");
    rx = 1'b1;
    wait_ticks(4);
    chk("break_exit_busy", busy, 0);
    wait_ticks(OS);

    // Overrun when the FIFO is full
    wr_if.fifo_full = 1'b1;
    model_frame(8'h81, 1'b1, 1'b1);
    send_frame(8'h81, 1'b1);
    rx = 1'b1;
    wait_ticks(OS);
    wr_if.fifo_full = 1'b0;
    compare_events("ovr");
    chk("ovr_data_held", wr_if.wr_data, model_data);

    // Reset in the middle of frame 0xFF, then a clean frame
    rx = 1'b0;
    wait_ticks(OS);
    rx = 1'b1;
    wait_ticks(4 * OS);
    reset = 1'b1;
    model_data = '0;
    repeat (3) @(negedge wr_clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_data", wr_if.wr_data, 0);
    reset = 1'b0;
    wait_ticks(5 * OS);
    model_frame(8'h12, 1'b1, 1'b0);
    send_frame(8'h12, 1'b1);
    rx = 1'b1;
    wait_ticks(OS);
    compare_events("midrst");
    chk("midrst_final_data", wr_if.wr_data, 8'h12);

    // Randomized frame stream
    for (int k = 0; k < 16; k++) begin
      d       = DB'($urandom);
      stop_ok = ($urandom_range(0, 4) != 0);
      full    = ($urandom_range(0, 3) == 0);
      gap     = stop_ok ? $urandom_range(0, 2) : $urandom_range(1, 2);
      wr_if.fifo_full = full;
      model_frame(d, stop_ok, full);
      send_frame(d, stop_ok);
      rx = 1'b1;
      if (gap > 0) wait_ticks(gap * OS + $urandom_range(0, 3));
    end
    wr_if.fifo_full = 1'b0;
    wait_ticks(2 * OS);
    compare_events("rand");
    chk("rand_data", wr_if.wr_data, model_data);
    chk("rand_busy", busy, 0);
    chk("excl_viol", excl_viol, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/zrb_uart_receiver.md
ZRB_UART_RECEIVER -- requirements
Module: zrb_uart_receiver

Interface
REQ-001 Parameter DATA_BITS, default 8, number of data bits per frame.
REQ-002 Parameter OVERSAMPLE, default 8, rx sample ticks per bit; SHALL be even and at least 4.
REQ-003 wr_clk  input  1  system clock; all state SHALL be on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 tick  input  1  one-wr_clk-cycle enable at OVERSAMPLE x baud, from the baud generator rx output.
REQ-006 rx  input  1  asynchronous serial line; idle high.
REQ-007 fifo_full  input  1  full flag of the downstream FIFO write port.
REQ-008 wr_en  output  1  one-cycle strobe; wr_data is valid in the same cycle.
REQ-009 wr_data  output  DATA_BITS  last received byte; held until the next accepted byte.
REQ-010 frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-011 overrun  output  1  one-cycle pulse when a good byte is dropped because fifo_full=1.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 rx SHALL pass through a 2-FF synchronizer (reset value 1) before any use; rx_s is the synchronizer output.
REQ-014 The FSM SHALL have the states IDLE, START, DATA, STOP and BREAK; the FSM and the tick counter SHALL advance only in cycles where tick=1.
REQ-015 IDLE: when rx_s=0 on a tick -> START, tick counter cleared.
REQ-016 Each bit is sampled at tick counts OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit, and the bit value SHALL be the majority of those 3 samples.
REQ-017 START: a voted 0 -> DATA; a voted 1 is a false start -> IDLE, with no outputs asserted.
REQ-018 DATA: one bit per OVERSAMPLE ticks, LSB first, shifted into a DATA_BITS shift register; after DATA_BITS bits -> STOP.
REQ-019 STOP, voted 1, fifo_full=0: wr_en=1 for exactly one wr_clk cycle, wr_data updated in that same cycle -> IDLE.
REQ-020 STOP, voted 1, fifo_full=1: overrun=1 for one cycle; wr_en stays 0; wr_data is not updated -> IDLE.
REQ-021 STOP, voted 0: frame_err=1 for one cycle; no wr_en -> BREAK.
REQ-022 BREAK: remain until rx_s=1 on a tick -> IDLE; this prevents a held-low line from producing repeated frames.
REQ-023 Transition to IDLE occurs at the stop-bit mid-point, so a start edge on the following tick SHALL be accepted (back-to-back frames).
REQ-024 Latency: wr_en SHALL assert on the tick following the last stop-bit sample, at most 2 wr_clk cycles after that tick.
REQ-025 wr_en, frame_err and overrun SHALL be mutually exclusive and never asserted while tick=0 except on that latency cycle.
REQ-026 The tick counter width SHALL be clog2(OVERSAMPLE); the bit counter SHALL be clog2(DATA_BITS+1); wrap to 0 at the bit boundary.

Reset
REQ-027 On reset: state=IDLE, counters=0, shift register=0, wr_data=0, wr_en=0, frame_err=0, overrun=0, busy=0, synchronizer=1.
REQ-028 Reset mid-frame SHALL abandon the frame with no wr_en/frame_err/overrun; reception SHALL resume at the next start edge after release.

Structure
REQ-029 The state encoding and the sample-point constants (OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1) SHALL live in the shared package zrb_uart_pkg.
REQ-030 The 2-FF synchronizer SHALL be a separate sub-module zrb_sync2 (parameterizable reset value); everything else is in one module.

Verification
REQ-031 Frame 0x55 at 8 ticks/bit, fifo_full=0 -> exactly one wr_en, wr_data=0x55, busy low afterwards.
REQ-032 Back-to-back frames 0xA3 then 0x0F, with no idle gap -> two wr_en strobes, data 0xA3 then 0x0F.
REQ-033 rx low glitch of 2 ticks -> no wr_en, no frame_err, FSM back in IDLE.
REQ-034 Frame 0x3C with stop bit 0, then rx held low 30 ticks -> one frame_err, no wr_en, stays in BREAK until rx=1.
REQ-035 Frame 0x81 with fifo_full=1 -> one overrun pulse, no wr_en, wr_data keeps its previous value.
REQ-036 reset asserted at data bit 4 of frame 0xFF, then a clean frame 0x12 -> only one wr_en, with wr_data=0x12.
